// File: rtl/t2sd_pkg.sv
// Shared definitions for the producer -> buffer -> display datapath.
package t2sd_pkg;
    localparam int BUF_WIDTH = 16;
    localparam int BUF_DEPTH = 8;
    typedef logic [BUF_WIDTH-1:0] sample_t;
endpackage

// File: rtl/buffer_ram.sv
// DEPTH x WIDTH register file: one synchronous write port and one
// combinational read port. Storage is deliberately left unreset.
module buffer_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Synchronous write of one entry per cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_buffer.sv
// Single-clock sample FIFO decoupling producer rate from consumer rate.
// Pops are registered: data_2 holds the last popped sample and
// data_2_valid pulses for the one cycle after each pop.
module data_buffer
    import t2sd_pkg::*;
#(
    parameter int WIDTH = BUF_WIDTH,
    parameter int DEPTH = BUF_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_1_en,
    input  logic [WIDTH-1:0] data_1,
    input  logic             rd_tick,
    output logic [WIDTH-1:0] data_2,
    output logic             data_2_valid,
    output logic             buffer_full,
    output logic             buffer_empty,
    output logic [CW-1:0]    count,
    output logic             overflow
);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] rd_data;
    logic             wr_ok;
    logic             rd_ok;

    // Flags come straight from the count register, so they are glitch-free.
    assign buffer_full  = (count == CW'(DEPTH));
    assign buffer_empty = (count == '0);

    // A pop frees a slot in the same cycle, so a full buffer still accepts
    // a write when it is popped at the same time. No fall-through on empty.
    assign rd_ok = rd_tick & ~buffer_empty;
    assign wr_ok = data_1_en & (~buffer_full | rd_ok);

    buffer_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (data_1),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Pointer, occupancy, output and sticky-overflow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            data_2       <= '0;
            data_2_valid <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            data_2_valid <= rd_ok;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                data_2 <= rd_data;
            end
            if (wr_ok && !rd_ok) begin
                count <= count + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                count <= count - 1'b1;
            end
            if (data_1_en && !wr_ok) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_buffer.sv
// Self-checking bench for data_buffer: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_data_buffer;

    localparam int W = 16;
    localparam int D = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          data_1_en = 1'b0;
    logic [W-1:0]  data_1 = '0;
    logic          rd_tick = 1'b0;
    logic [W-1:0]  data_2;
    logic          data_2_valid;
    logic          buffer_full;
    logic          buffer_empty;
    logic [3:0]    count;
    logic          overflow;

    int tests  = 0;
    int failed = 0;

    // reference model state
    logic [W-1:0] q[$];
    logic [W-1:0] m_d2  = '0;
    logic         m_v   = 1'b0;
    logic         m_ovf = 1'b0;

    data_buffer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_1_en    (data_1_en),
        .data_1       (data_1),
        .rd_tick      (rd_tick),
        .data_2       (data_2),
        .data_2_valid (data_2_valid),
        .buffer_full  (buffer_full),
        .buffer_empty (buffer_empty),
        .count        (count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO model: pop the oldest if anything is stored, then accept the write
    // if there is room after that pop; otherwise the write is dropped.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_d2  = '0;
            m_v   = 1'b0;
            m_ovf = 1'b0;
        end else begin
            logic pop, push;
            pop  = rd_tick && (q.size() > 0);
            push = data_1_en && ((q.size() < D) || pop);
            m_v  = pop;
            if (pop) m_d2 = q.pop_front();
            if (push) q.push_back(data_1);
            if (data_1_en && !push) m_ovf = 1'b1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_count", 32'(count), 32'(q.size()));
        chk("m_full",  32'(buffer_full),  32'(q.size() == D));
        chk("m_empty", 32'(buffer_empty), 32'(q.size() == 0));
        chk("m_data2", 32'(data_2), 32'(m_d2));
        chk("m_valid", 32'(data_2_valid), 32'(m_v));
        chk("m_ovf",   32'(overflow), 32'(m_ovf));
    end

    task automatic step(input logic en, input logic [W-1:0] d, input logic tk);
        data_1_en = en;
        data_1    = d;
        rd_tick   = tk;
        @(posedge clk);
        #1;
        data_1_en = 1'b0;
        data_1    = '0;
        rd_tick   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [W-1:0] fib [8];
        fib = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21};

        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // reset then idle
        chk("rst_empty", 32'(buffer_empty), 32'd1);
        chk("rst_full",  32'(buffer_full),  32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_data2", 32'(data_2), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, 1'b1);
            chk("idle_tick_valid", 32'(data_2_valid), 32'd0);
        end

        // fill with Fibonacci, overflow on the ninth, drain in order
        for (int i = 0; i < 8; i++) step(1'b1, fib[i], 1'b0);
        chk("fill_full",  32'(buffer_full), 32'd1);
        chk("fill_count", 32'(count), 32'd8);
        step(1'b1, 16'd34, 1'b0);
        chk("ovf_set",   32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, 1'b1);
            chk("fib_data",  32'(data_2), 32'(fib[i]));
            chk("fib_valid", 32'(data_2_valid), 32'd1);
        end
        step(1'b0, '0, 1'b0);
        chk("fib_valid_drop", 32'(data_2_valid), 32'd0);
        chk("drain_empty", 32'(buffer_empty), 32'd1);
        chk("ovf_sticky",  32'(overflow), 32'd1);

        // full with simultaneous write and read
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, W'(100 + i), 1'b0);
        step(1'b1, 16'd55, 1'b1);
        chk("fullrw_data",  32'(data_2), 32'd100);
        chk("fullrw_count", 32'(count), 32'd8);
        chk("fullrw_ovf",   32'(overflow), 32'd0);
        for (int i = 1; i < 8; i++) begin
            step(1'b0, '0, 1'b1);
            chk("fullrw_drain", 32'(data_2), 32'(100 + i));
        end
        step(1'b0, '0, 1'b1);
        chk("fullrw_last", 32'(data_2), 32'd55);
        chk("fullrw_empty", 32'(buffer_empty), 32'd1);

        // empty with simultaneous write and read: no fall-through
        step(1'b1, 16'h00AA, 1'b1);
        chk("emptyrw_count", 32'(count), 32'd1);
        chk("emptyrw_valid", 32'(data_2_valid), 32'd0);
        chk("emptyrw_hold",  32'(data_2), 32'd55);
        step(1'b0, '0, 1'b1);
        chk("emptyrw_data",  32'(data_2), 32'h00AA);
        chk("emptyrw_valid2", 32'(data_2_valid), 32'd1);

        // pointer wrap with interleaved pairs
        for (int i = 0; i < 20; i++) begin
            step(1'b1, W'(i), 1'b0);
            chk("wrap_cnt_le1", 32'(count <= 4'd1), 32'd1);
            step(1'b0, '0, 1'b1);
            chk("wrap_data", 32'(data_2), 32'(i));
        end

        // asynchronous reset mid-burst, with overflow previously set
        for (int i = 0; i < 9; i++) step(1'b1, W'(16'h0F00 + i), 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        chk("pre_rst_count", 32'(count), 32'd5);
        chk("pre_rst_ovf",   32'(overflow), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_empty", 32'(buffer_empty), 32'd1);
        chk("midrst_full",  32'(buffer_full), 32'd0);
        chk("midrst_data2", 32'(data_2), 32'd0);
        chk("midrst_valid", 32'(data_2_valid), 32'd0);
        chk("midrst_ovf",   32'(overflow), 32'd0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 16'h1234, 1'b0);
        step(1'b0, '0, 1'b1);
        chk("postrst_data",  32'(data_2), 32'h1234);
        chk("postrst_valid", 32'(data_2_valid), 32'd1);
        chk("postrst_empty", 32'(buffer_empty), 32'd1);

        step(1'b0, '0, 1'b0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/data_buffer.md
# data_buffer

Single-clock FIFO between the Fibonacci/Timer producers and the display consumer. It decouples producer rate from consumer rate. It stores 16-bit samples written on `data_1_en`, pops one per consumer tick to `data_2`, and reports `buffer_full`/`buffer_empty`. The top-level state machine uses these flags to pause a producer (S_WAIT_F/S_WAIT_T) and to detect drain completion (S_BUF_EMPTY exits when `buffer_empty` and not `data_2_valid`).

## Interface
Parameters:
- `WIDTH`, 16: sample width in bits.
- `DEPTH`, 8: number of entries. Must be a power of two, ≥2.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: reset, asynchronous, active-high.
- `data_1_en` in 1: write strobe, one clk cycle per sample.
- `data_1` in WIDTH: write data, sampled when `data_1_en`=1.
- `rd_tick` in 1: consumer-rate strobe, one clk cycle wide, from the slow-clock generator.
- `data_2` out WIDTH: last popped sample. Held until the next pop.
- `data_2_valid` out 1: one-cycle pulse when `data_2` has just been updated.
- `buffer_full` out 1: count == DEPTH.
- `buffer_empty` out 1: count == 0.
- `count` out $clog2(DEPTH)+1: current occupancy.
- `overflow` out 1: sticky. Set when a write is dropped.

## Operation
- State: `wr_ptr` and `rd_ptr` ($clog2(DEPTH) bits each, natural wrap from DEPTH-1 to 0), `count` register, storage array `mem[DEPTH]`.
- Accept write: `wr_ok = data_1_en & (~buffer_full | rd_ok)`.
  - Effect: `mem[wr_ptr] <= data_1`, then `wr_ptr++`.
- Pop: `rd_ok = rd_tick & ~buffer_empty`.
  - Effect: `data_2 <= mem[rd_ptr]`, then `rd_ptr++`, and `data_2_valid <= 1`.
  - `data_2_valid` is 0 on every cycle without a pop.
- Count update: +1 on write only; −1 on read only; unchanged when both or neither occur.
- Full and simultaneous read+write: both occur. The read returns the oldest entry; the new data lands in the freed slot; count stays DEPTH.
- Empty and simultaneous read+write: no fall-through. The write is accepted, no pop happens, count becomes 1, and `data_2_valid` stays 0.
- Write when full without a read: data is dropped, pointers and count are unchanged, and `overflow` is set to 1 until reset.
- `rd_tick` when empty: ignored. `data_2` is held and `data_2_valid` stays 0.
- Flags are decoded from the `count` register, so they are glitch-free and need no extra register stage.
- Reset, including mid-operation: asynchronous clear of `wr_ptr`, `rd_ptr`, `count`, `data_2` (0), `data_2_valid` (0), `overflow` (0).
  - After reset, `buffer_empty`=1 and `buffer_full`=0.
  - Stored contents are discarded. `mem` itself is not reset.

## Timing
- Write at edge n: `count`/flags update at edge n; visible to the top state machine in cycle n+1.
- Write-to-read latency: a sample written at edge n can be popped by `rd_tick` sampled at edge n+1. `data_2`/`data_2_valid` appear after edge n+1.
- Pop latency: `rd_tick` high in cycle k means `data_2` and `data_2_valid` change at the end of cycle k (registered, 1-cycle). `data_2_valid` is high for exactly cycle k+1.
- Drain complete: after the last pop, `buffer_empty`=1 and `data_2_valid`=1 for one cycle. In the following cycle both conditions for S_BUF_EMPTY exit hold.
- The top reacts to `buffer_full` one cycle late, so one extra `data_1_en` may arrive after full. It is handled by the drop/overflow rule, and the producer must retry.
- Maximum throughput: one write and one read per clk cycle.

## Structure
- Shared package `t2sd_pkg`: `BUF_WIDTH`=16, `BUF_DEPTH`=8, and `typedef logic [BUF_WIDTH-1:0] sample_t`. The producers and the display module also import it.
- One natural sub-module: `buffer_ram`, a DEPTH×WIDTH register file.
  - One synchronous write port and one combinational read port.
  - No reset on storage.
- Pointer, count and flag logic stays in `data_buffer`.

## Test plan
- Reset then idle: `buffer_empty`=1, `buffer_full`=0, `count`=0, `data_2`=0. Ten `rd_tick` pulses produce no `data_2_valid`.
- Write 1,1,2,3,5,8,13,21 (8 strobes): `buffer_full`=1, `count`=8. A 9th write of 34 sets `overflow`=1 and leaves `count`=8. Eight `rd_tick`s then return 1,1,2,3,5,8,13,21 in order, each with a single-cycle `data_2_valid`, ending with `buffer_empty`=1.
- Full plus simultaneous `data_1_en`(55) and `rd_tick`: `data_2`=oldest entry, `count` stays 8, no `overflow`. 55 is read back last.
- Empty plus simultaneous write(0x00AA) and `rd_tick`: `count`=1, `data_2_valid`=0. The next `rd_tick` yields `data_2`=0x00AA.
- Pointer wrap: 20 interleaved write/read pairs with values 0..19 read back in exact order. `count` never exceeds 1.
- Assert `rst` mid-burst with `count`=5: all outputs return to reset values in the same cycle. The following write of 0x1234 plus `rd_tick` yields 0x1234, not stale data.
